// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the SPI master transfer controller.
package spi_master_pkg;

    localparam int unsigned SPI_DATA_W = 32;
    localparam int unsigned SPI_LEN_W  = $clog2(SPI_DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } xfer_state_e;

    typedef struct packed {
        logic [SPI_DATA_W-1:0] tx_data;
        logic [SPI_LEN_W-1:0]  len;
    } cmd_t;

endpackage

// File: rtl/spi_master_shifter.sv
// MSB-first TX/RX shift registers and bit counter for one mode-0 SPI transfer.
module spi_master_shifter
    import spi_master_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W,
    parameter int unsigned LEN_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              rise,
    input  logic              fall,
    input  logic              sdi,
    output logic              sdo,
    output logic [DATA_W-1:0] rx_word,
    output logic              last
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W - 1);

    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q   <= '0;
            rx_q   <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    // Load MSB-aligns the word; rise samples, fall launches the next bit.
    always_comb begin
        tx_d   = tx_q;
        rx_d   = rx_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (load) begin
            tx_d   = load_data << (LEN_MAX - load_len);
            rx_d   = '0;
            len_d  = load_len;
            cnt_d  = '0;
            last_d = 1'b0;
        end else if (rise) begin
            rx_d  = {rx_q[DATA_W-2:0], sdi};
            cnt_d = cnt_q + LEN_W'(1);
            if (cnt_q == len_q) begin
                last_d = 1'b1;
            end
        end else if (fall) begin
            if (!last_q) begin
                tx_d = tx_q << 1;
            end
        end
    end

    assign sdo     = tx_q[DATA_W-1];
    assign rx_word = rx_q;
    assign last    = last_q;

endmodule

// File: rtl/spi_master_xfer_ctrl.sv
// SPI mode-0 transfer sequencer: CS setup, clock gating, shifting, CS hold and
// result delivery around an external clock generator.
module spi_master_xfer_ctrl
    import spi_master_pkg::*;
#(
    parameter int unsigned DATA_W       = SPI_DATA_W,
    parameter int unsigned LEN_W        = $clog2(DATA_W),
    parameter int unsigned CS_SETUP_CYC = 2,
    parameter int unsigned CS_HOLD_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_tx_data,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    output logic              busy,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              clkgen_en,
    input  logic              spi_rise,
    input  logic              spi_fall,
    output logic              spi_csn,
    output logic              spi_sdo,
    input  logic              spi_sdi
);

    localparam int unsigned TMR_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    xfer_state_e       state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              aborted_q, aborted_d;
    logic              sclk_high_q, sclk_high_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              clkgen_en_q, clkgen_en_d;
    logic              csn_q, csn_d;

    logic              sh_load;
    logic              sh_rise;
    logic              sh_fall;
    logic              sh_last;
    logic [DATA_W-1:0] sh_rx_word;

    assign sh_rise = spi_rise && (state_q == XFER);
    assign sh_fall = spi_fall && (state_q == XFER);

    spi_master_shifter #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (cmd_tx_data),
        .load_len  (cmd_len),
        .rise      (sh_rise),
        .fall      (sh_fall),
        .sdi       (spi_sdi),
        .sdo       (spi_sdo),
        .rx_word   (sh_rx_word),
        .last      (sh_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            aborted_q   <= 1'b0;
            sclk_high_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            clkgen_en_q <= 1'b0;
            csn_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            aborted_q   <= aborted_d;
            sclk_high_q <= sclk_high_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            clkgen_en_q <= clkgen_en_d;
            csn_q       <= csn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        aborted_d   = aborted_q;
        sclk_high_d = sclk_high_q;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        sh_load     = 1'b0;

        // SCLK level is tracked in every state so HOLD can wait out a trailing fall.
        if (spi_rise) begin
            sclk_high_d = 1'b1;
        end else if (spi_fall) begin
            sclk_high_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    sh_load   = 1'b1;
                    tmr_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    tmr_d     = '0;
                    state_d   = HOLD;
                end else if (tmr_q == TMR_W'(CS_SETUP_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = XFER;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            XFER: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    tmr_d     = '0;
                    state_d   = HOLD;
                end else if (spi_fall && sh_last) begin
                    tmr_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!sclk_high_q) begin
                    if (tmr_q == TMR_W'(CS_HOLD_CYC - 1)) begin
                        state_d    = DONE;
                        rx_valid_d = !aborted_q;
                        if (!aborted_q) begin
                            rx_data_d = sh_rx_word;
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status and pin outputs are registered images of the next state.
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        clkgen_en_d = (state_d == XFER);
        csn_d       = !(state_d inside {SETUP, XFER, HOLD});
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign clkgen_en = clkgen_en_q;
    assign spi_csn   = csn_q;

endmodule
